e32_config_controller: RTL
==========================

Name: e32_config_controller

Overview:
- Command sequencer for the E32 transceiver while it is in stand-by/config mode (mode 3, {M1_sync,M0_sync}=2'b11).
- Parses host UART command bytes: write params C0/C2, read params C1x3, version C3x3, reset C4x3.
- Owns the working parameter registers (ADDH/ADDL/SPED/CHAN/OPTION) that configure the RF datapath.
- Sequences response bytes back to the UART TX path and drives an AUX contribution that is low while busy.

Parameters:
DEFAULT_ADDH, 8'h00, reset value of ADDH
DEFAULT_ADDL, 8'h00, reset value of ADDL
DEFAULT_SPED, 8'h1A, reset value of SPED
DEFAULT_CHAN, 8'h17, reset value of CHAN
DEFAULT_OPTION, 8'h44, reset value of OPTION
VERSION_MODEL, 8'h32, 2nd byte of version response
VERSION_NUM, 8'h10, 3rd byte of version response
VERSION_FEAT, 8'h14, 4th byte of version response
RESET_CYCLES, 10000, AUX-low duration after a C4 reset command (>=1)
CMD_TIMEOUT, 5000, max idle cycles between bytes of one command (>=1)

Ports:
internal_clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
mode_sleep  in  1  high when {M1_sync,M0_sync}==2'b11
rx_data  in  8  received UART byte
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  response byte
tx_valid  out  1  response byte valid; held until accepted
tx_ready  in  1  UART TX accepts byte when tx_valid&tx_ready
AUX_config_ctrl  out  1  1=idle, 0=busy
addh, addl, sped, chan, option  out  8 each  working parameters
param_update  out  1  one-cycle pulse when the working params are committed
param_save  out  1  one-cycle pulse with param_update when the head byte is C0
soft_reset_req  out  1  one-cycle pulse on accepted C4x3

Behaviour:
- Clock and reset: one clock internal_clk; reset rst_n is synchronous, active-low.
- Reset values:
  - params = DEFAULT_*.
  - tx_data=0, tx_valid=0, AUX_config_ctrl=1, all pulses=0, state=IDLE.
- States: IDLE, WRITE_COLLECT, REPEAT_COLLECT, RESP, RESET_WAIT.
- IDLE: accepts rx_valid only when mode_sleep=1.
  - C0/C2: latch head, idx=0, go WRITE_COLLECT.
  - C1/C3/C4: latch head, rep=1, go REPEAT_COLLECT.
  - Any other byte: ignored, stay IDLE.
- WRITE_COLLECT:
  - Each rx_valid byte is stored into shadow[idx], idx++.
  - On the 5th byte, the next cycle does all of:
    - copies shadow to the working params;
    - pulses param_update, and also param_save if head==C0;
    - loads a 6-byte response {head,ADDH,ADDL,SPED,CHAN,OPTION}, using the new values;
    - goes to RESP.
- REPEAT_COLLECT:
  - A byte equal to head increments rep.
  - A byte not equal to head aborts to IDLE; that byte is discarded, not reinterpreted.
  - At rep==3:
    - C1: response {C0,ADDH,ADDL,SPED,CHAN,OPTION}, go RESP.
    - C3: response {C3,VERSION_MODEL,VERSION_NUM,VERSION_FEAT}, go RESP.
    - C4: pulse soft_reset_req, restore params to DEFAULT_*, go RESET_WAIT.
- RESP:
  - tx_valid=1, tx_data=resp[ptr].
  - ptr advances on tx_valid&tx_ready. tx_data is stable while tx_ready=0.
  - After the last byte is accepted: tx_valid=0 the next cycle, go IDLE.
  - rx_valid in RESP is dropped.
- RESET_WAIT: count RESET_CYCLES cycles, then go IDLE. rx_valid is dropped.
- AUX_config_ctrl:
  - Goes 0 the cycle after the first command byte is accepted.
  - Stays 0 in every non-IDLE state; returns to 1 on re-entry to IDLE.
- Leaving sleep mode (mode_sleep 1->0) in any non-IDLE state:
  - Next cycle: state=IDLE, tx_valid=0, AUX=1.
  - Partial shadow is discarded; params are unchanged unless already committed.
  - A RESET_WAIT in progress is aborted.
- rx_valid and the commit cycle coinciding: the byte is dropped.
- Response lengths: 6 or 4 bytes. ptr is 3 bits and never wraps past the length.

Optional Feature:
- Macro: E32_CFG_TIMEOUT_EN.
- Defined:
  - A gap counter clears on each accepted byte and counts in WRITE_COLLECT/REPEAT_COLLECT.
  - On reaching CMD_TIMEOUT, the next cycle goes to IDLE, discards the partial command and sets AUX=1.
  - There is no param_update.
- Undefined:
  - No counter.
  - A partial command waits indefinitely until it completes, a mismatch occurs, mode_sleep falls, or reset.

Test Plan:
- mode_sleep=1; send C0,12,34,1A,05,44 with tx_ready=1:
  - addh=12, addl=34, chan=05;
  - param_update and param_save pulse once;
  - tx emits C0,12,34,1A,05,44;
  - AUX 0 then 1.
- After reset, send C1,C1,C1; hold tx_ready=0 for 10 cycles, then 1 -> tx_data holds C0 while stalled, then sequence C0,00,00,1A,17,44; then IDLE.
- Send C3,C3,C3 -> tx C3,32,10,14. Then send C3,C1 -> no response; the C1 is discarded; state IDLE.
- Write C2 params (chan=09), then C4,C4,C4:
  - param_save is not pulsed for C2;
  - soft_reset_req pulses;
  - chan returns to 17;
  - AUX low exactly RESET_CYCLES (+1) cycles.
- Send C0,AA,BB, then drop mode_sleep -> next cycle IDLE, AUX=1, params unchanged. Bytes with mode_sleep=0 are ignored.
- With E32_CFG_TIMEOUT_EN: send C0,01, then wait CMD_TIMEOUT cycles -> IDLE, no param_update. A following C1x3 read returns the defaults.

Source files
------------

// File: rtl/e32_config_controller_if.sv
// rtl/e32_config_controller_if.sv - UART byte handshake bundle between host UART and the E32 config controller
interface e32_config_controller_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  // UART side: delivers received bytes, accepts response bytes
  modport master (
    output rx_data,
    output rx_valid,
    output tx_ready,
    input  tx_data,
    input  tx_valid
  );

  // Controller side
  modport slave (
    input  rx_data,
    input  rx_valid,
    input  tx_ready,
    output tx_data,
    output tx_valid
  );
endinterface

// File: rtl/e32_config_controller.sv
// rtl/e32_config_controller.sv - E32 config-mode command sequencer; optional gap timeout under E32_CFG_TIMEOUT_EN
module e32_config_controller #(
  parameter logic [7:0] DEFAULT_ADDH   = 8'h00,
  parameter logic [7:0] DEFAULT_ADDL   = 8'h00,
  parameter logic [7:0] DEFAULT_SPED   = 8'h1A,
  parameter logic [7:0] DEFAULT_CHAN   = 8'h17,
  parameter logic [7:0] DEFAULT_OPTION = 8'h44,
  parameter logic [7:0] VERSION_MODEL  = 8'h32,
  parameter logic [7:0] VERSION_NUM    = 8'h10,
  parameter logic [7:0] VERSION_FEAT   = 8'h14,
  parameter int         RESET_CYCLES   = 10000,
  parameter int         CMD_TIMEOUT    = 5000
) (
  input  logic                          internal_clk,
  input  logic                          rst_n,
  input  logic                          mode_sleep,
  e32_config_controller_if.slave        bus,
  output logic                          AUX_config_ctrl,
  output logic [7:0]                    addh,
  output logic [7:0]                    addl,
  output logic [7:0]                    sped,
  output logic [7:0]                    chan,
  output logic [7:0]                    option,
  output logic                          param_update,
  output logic                          param_save,
  output logic                          soft_reset_req
);

  typedef enum logic [2:0] {
    IDLE, WRITE_COLLECT, REPEAT_COLLECT, RESP, RESET_WAIT
  } state_t;

  localparam logic [7:0] CMD_C0 = 8'hC0;
  localparam logic [7:0] CMD_C1 = 8'hC1;
  localparam logic [7:0] CMD_C2 = 8'hC2;
  localparam logic [7:0] CMD_C3 = 8'hC3;
  localparam logic [7:0] CMD_C4 = 8'hC4;

  // Counter only has to reach RESET_CYCLES-1
  localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  state_t       state_q, state_d;
  logic [7:0]   head_q, head_d;
  logic [2:0]   idx_q, idx_d;
  logic [1:0]   rep_q, rep_d;
  logic [7:0]   shadow_q [5];
  logic [7:0]   shadow_d [5];
  logic [7:0]   param_q [5];
  logic [7:0]   param_d [5];
  logic [7:0]   resp_q [6];
  logic [7:0]   resp_d [6];
  logic [2:0]   resp_len_q, resp_len_d;
  logic [2:0]   ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         update_q, update_d;
  logic         save_q, save_d;
  logic         srst_q, srst_d;

  logic rx_acc;
  logic abort_sleep;
  logic timeout_hit;
  logic abort_w;
  logic commit_w;
  logic rep_done_w;
  logic rep_mismatch;
  logic tx_fire;
  logic last_fire;
  logic reset_done;
  logic is_write_cmd;
  logic is_rep_cmd;

  assign rx_acc       = bus.rx_valid && mode_sleep;
  assign abort_sleep  = !mode_sleep && (state_q != IDLE);
  assign abort_w      = abort_sleep || timeout_hit;
  // Commit/finish happen one cycle after the final byte, so a byte landing then is dropped
  assign commit_w     = (state_q == WRITE_COLLECT) && (idx_q == 3'd5);
  assign rep_done_w   = (state_q == REPEAT_COLLECT) && (rep_q == 2'd3);
  assign rep_mismatch = (state_q == REPEAT_COLLECT) && !rep_done_w && rx_acc
                        && (bus.rx_data != head_q);
  assign tx_fire      = (state_q == RESP) && bus.tx_ready;
  assign last_fire    = tx_fire && (ptr_q == (resp_len_q - 3'd1));
  assign reset_done   = (state_q == RESET_WAIT) && (cnt_q == CW'(RESET_CYCLES - 1));
  assign is_write_cmd = (bus.rx_data == CMD_C0) || (bus.rx_data == CMD_C2);
  assign is_rep_cmd   = (bus.rx_data == CMD_C1) || (bus.rx_data == CMD_C3)
                        || (bus.rx_data == CMD_C4);

`ifdef E32_CFG_TIMEOUT_EN
  localparam int GW = $clog2(CMD_TIMEOUT + 1);
  logic [GW-1:0] gap_q, gap_d;
  logic          collecting;

  assign collecting  = (state_q == WRITE_COLLECT) || (state_q == REPEAT_COLLECT);
  assign timeout_hit = collecting && (gap_q == GW'(CMD_TIMEOUT));

  // Idle-gap counter: cleared by every accepted byte, saturates at the limit
  always_comb begin
    gap_d = '0;
    if (collecting && !rx_acc && (gap_q != GW'(CMD_TIMEOUT))) gap_d = gap_q + GW'(1);
  end

  // Gap counter register
  always_ff @(posedge internal_clk) begin
    if (!rst_n) gap_q <= '0;
    else        gap_q <= gap_d;
  end
`else
  logic unused_timeout_cfg;
  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = (CMD_TIMEOUT < 1);
`endif

  // State register
  always_ff @(posedge internal_clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; sleep exit and timeout override everything
  always_comb begin
    state_d = state_q;
    if (abort_w) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_acc && is_write_cmd)    state_d = WRITE_COLLECT;
          else if (rx_acc && is_rep_cmd) state_d = REPEAT_COLLECT;
        end
        WRITE_COLLECT:  if (commit_w) state_d = RESP;
        REPEAT_COLLECT: begin
          if (rep_done_w)        state_d = (head_q == CMD_C4) ? RESET_WAIT : RESP;
          else if (rep_mismatch) state_d = IDLE;
        end
        RESP:       if (last_fire)  state_d = IDLE;
        RESET_WAIT: if (reset_done) state_d = IDLE;
        default:    state_d = IDLE;
      endcase
    end
  end

  // Datapath next values: byte capture, commit, response loading, counters
  always_comb begin
    head_d     = head_q;
    idx_d      = idx_q;
    rep_d      = rep_q;
    shadow_d   = shadow_q;
    param_d    = param_q;
    resp_d     = resp_q;
    resp_len_d = resp_len_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    update_d   = 1'b0;
    save_d     = 1'b0;
    srst_d     = 1'b0;
    if (!abort_w) begin
      case (state_q)
        IDLE: begin
          if (rx_acc && (is_write_cmd || is_rep_cmd)) begin
            head_d = bus.rx_data;
            idx_d  = 3'd0;
            rep_d  = 2'd1;
          end
        end
        WRITE_COLLECT: begin
          if (commit_w) begin
            param_d    = shadow_q;
            update_d   = 1'b1;
            save_d     = (head_q == CMD_C0);
            resp_d[0]  = head_q;
            for (int i = 0; i < 5; i++) resp_d[i+1] = shadow_q[i];
            resp_len_d = 3'd6;
            ptr_d      = 3'd0;
          end else if (rx_acc) begin
            shadow_d[idx_q] = bus.rx_data;
            idx_d           = idx_q + 3'd1;
          end
        end
        REPEAT_COLLECT: begin
          if (rep_done_w) begin
            ptr_d = 3'd0;
            if (head_q == CMD_C1) begin
              resp_d[0] = CMD_C0;
              for (int i = 0; i < 5; i++) resp_d[i+1] = param_q[i];
              resp_len_d = 3'd6;
            end else if (head_q == CMD_C3) begin
              resp_d[0]  = CMD_C3;
              resp_d[1]  = VERSION_MODEL;
              resp_d[2]  = VERSION_NUM;
              resp_d[3]  = VERSION_FEAT;
              resp_len_d = 3'd4;
            end else begin
              srst_d     = 1'b1;
              param_d[0] = DEFAULT_ADDH;
              param_d[1] = DEFAULT_ADDL;
              param_d[2] = DEFAULT_SPED;
              param_d[3] = DEFAULT_CHAN;
              param_d[4] = DEFAULT_OPTION;
              cnt_d      = '0;
            end
          end else if (rx_acc && (bus.rx_data == head_q)) begin
            rep_d = rep_q + 2'd1;
          end
        end
        RESP:       if (tx_fire) ptr_d = ptr_q + 3'd1;
        RESET_WAIT: cnt_d = cnt_q + CW'(1);
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge internal_clk) begin
    if (!rst_n) begin
      head_q     <= 8'h00;
      idx_q      <= 3'd0;
      rep_q      <= 2'd0;
      for (int i = 0; i < 5; i++) shadow_q[i] <= 8'h00;
      param_q[0] <= DEFAULT_ADDH;
      param_q[1] <= DEFAULT_ADDL;
      param_q[2] <= DEFAULT_SPED;
      param_q[3] <= DEFAULT_CHAN;
      param_q[4] <= DEFAULT_OPTION;
      for (int i = 0; i < 6; i++) resp_q[i] <= 8'h00;
      resp_len_q <= 3'd0;
      ptr_q      <= 3'd0;
      cnt_q      <= '0;
      update_q   <= 1'b0;
      save_q     <= 1'b0;
      srst_q     <= 1'b0;
    end else begin
      head_q     <= head_d;
      idx_q      <= idx_d;
      rep_q      <= rep_d;
      shadow_q   <= shadow_d;
      param_q    <= param_d;
      resp_q     <= resp_d;
      resp_len_q <= resp_len_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      update_q   <= update_d;
      save_q     <= save_d;
      srst_q     <= srst_d;
    end
  end

  // Outputs: busy/tx qualifiers follow the registered state
  always_comb begin
    AUX_config_ctrl = (state_q == IDLE);
    bus.tx_valid    = (state_q == RESP);
    bus.tx_data     = (state_q == RESP) ? resp_q[ptr_q] : 8'h00;
    addh            = param_q[0];
    addl            = param_q[1];
    sped            = param_q[2];
    chan            = param_q[3];
    option          = param_q[4];
    param_update    = update_q;
    param_save      = save_q;
    soft_reset_req  = srst_q;
  end

endmodule
